// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared FSM state type and default operand/chunk widths for seq_chunk_adder
package seq_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// chunk_adder: CHUNK-bit ripple-carry adder built from 1-bit full adders
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;
    assign c[0] = cin;
    assign cout = c[CHUNK];
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first; optional signed overflow flag under SEQ_ADD_OVF_EN
module seq_chunk_adder
    import seq_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             co_q, co_d;
    logic [CHUNK-1:0] ca, cb, csum;
    logic             ccout;
    logic             last;

    assign ca   = a_q[cnt_q*CHUNK +: CHUNK];
    assign cb   = b_q[cnt_q*CHUNK +: CHUNK];
    assign last = cnt_q == CW'(NCH - 1);
    assign S    = s_q;
    assign Co   = co_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a(ca), .b(cb), .cin(carry_q), .sum(csum), .cout(ccout)
    );

    // Capture operands on start, fold one chunk per RUN cycle, pulse DONE once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = X;
                b_d     = sub ? ~Y : Y;
                carry_d = sub | Ci;
                cnt_d   = '0;
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            s_d[cnt_q*CHUNK +: CHUNK] = csum;
            carry_d = ccout;
            cnt_d   = last ? cnt_q : cnt_q + CW'(1);
            state_d = last ? DONE : RUN;
            co_d    = last ? ccout : co_q;
        end else begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

`ifdef SEQ_ADD_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;

    // Overflow = carry into MSB xor carry out of MSB, latched with the final chunk
    always_comb begin
        ovf_d = (state_q == RUN && last)
              ? (ca[CHUNK-1] ^ cb[CHUNK-1] ^ csum[CHUNK-1]) ^ ccout
              : ovf_q;
    end

    // Overflow register, held like S between operations
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: randomized and directed checks of seq_chunk_adder against an arithmetic reference model
module tb_seq_chunk_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start1 = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] X = '0, Y = '0;
    logic        Ci = 1'b0;
    logic [15:0] S, S1;
    logic        Co, busy, done, ovf;
    logic        Co1, busy1, done1, ovf1;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .X(X), .Y(Y), .Ci(Ci),
        .S(S), .Co(Co), .busy(busy), .done(done), .ovf(ovf)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .X(X), .Y(Y), .Ci(Ci),
        .S(S1), .Co(Co1), .busy(busy1), .done(done1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as the user sees them
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb,
                         output logic [15:0] es, output logic eco, output logic eovf);
        logic [15:0] ye;
        logic [16:0] tot;
        ye   = sb ? ~y : y;
        tot  = {1'b0, x} + {1'b0, ye} + 17'(sb ? 1'b1 : ci);
        es   = tot[15:0];
        eco  = tot[16];
`ifdef SEQ_ADD_OVF_EN
        eovf = (x[15] == ye[15]) && (es[15] != x[15]);
`else
        eovf = 1'b0;
`endif
    endtask

    task automatic op(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb,
                      input bit disturb);
        logic [15:0] es;
        logic eco, eovf;
        int lat;
        model(x, y, ci, sb, es, eco, eovf);
        @(negedge clk);
        X = x; Y = y; Ci = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (disturb && k <= 4) begin
                X = 16'($urandom); Y = 16'($urandom); Ci = ~Ci; sub = ~sub; start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (k == 1) check("busy_run", busy, 1'b1);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check("latency", lat, 4);
        check("sum", S, es);
        check("carry", Co, eco);
        check("ovf", ovf, eovf);
        check("busy_done", busy, 1'b1);
        @(posedge clk);
        #1;
        check("done_once", done, 1'b0);
        check("idle", busy, 1'b0);
        X = ~X; Y = ~Y;
        @(posedge clk);
        #1;
        check("hold_sum", S, es);
        check("hold_carry", Co, eco);
        check("hold_ovf", ovf, eovf);
    endtask

    initial begin
        bit saw;
        repeat (2) @(posedge clk);
        #1;
        check("rst_S", S, 16'h0);
        check("rst_Co", Co, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("wrap_S", S, 16'h0000);
        check("wrap_Co", Co, 1'b1);
        op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        check("borrow_S", S, 16'hFFFE);
        check("borrow_Co", Co, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("sovf_S", S, 16'h8000);
`ifdef SEQ_ADD_OVF_EN
        check("sovf_flag", ovf, 1'b1);
`else
        check("sovf_flag", ovf, 1'b0);
`endif
        op(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1);
        op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);

        @(negedge clk);
        X = 16'hAAAA; Y = 16'h5555; Ci = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_S", S, 16'h0);
        check("abort_Co", Co, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw |= done;
        end
        check("abort_no_done", saw, 1'b0);

        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_over_start", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        op(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        @(negedge clk);
        X = 16'h1234; Y = 16'h4321; Ci = 1'b1; sub = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("n1_busy", busy1, 1'b1);
        check("n1_not_done", done1, 1'b0);
        @(posedge clk);
        #1;
        check("n1_done", done1, 1'b1);
        check("n1_S", S1, 16'h5556);
        check("n1_Co", Co1, 1'b0);
        @(posedge clk);
        #1;
        check("n1_idle", busy1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
